// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: TileLink-UL opcodes, widths and the A-channel field bundle shared by the arbiter
package tl_ul_pkg;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        GET              = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [1:0]        size;
        logic              source;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } a_hdr_t;
endpackage

// File: rtl/tl_inflight_ctr.sv
// tl_inflight_ctr: per-master outstanding-request counter that never wraps below zero
module tl_inflight_ctr #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         zero,
    output logic         underflow
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        zero      = cnt_q == '0;
        full      = cnt_q == W'(MAX);
        underflow = dec && zero;
        cnt       = cnt_q;
        cnt_d     = (inc && !dec) ? cnt_q + 1'b1 : (dec && !inc && !zero) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tl_ul_arbiter2.sv
// tl_ul_arbiter2: round-robin two-master TileLink-UL arbiter with source tagging and in-flight caps
module tl_ul_arbiter2
    import tl_ul_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2,
    parameter int ADDR_W       = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_a_valid,
    output logic              m0_a_ready,
    input  logic [2:0]        m0_a_opcode,
    input  logic [2:0]        m0_a_param,
    input  logic [1:0]        m0_a_size,
    input  logic              m0_a_source,
    input  logic [ADDR_W-1:0] m0_a_address,
    input  logic [MASK_W-1:0] m0_a_mask,
    input  logic [DATA_W-1:0] m0_a_data,
    output logic              m0_d_valid,
    input  logic              m0_d_ready,
    output logic [2:0]        m0_d_opcode,
    output logic [1:0]        m0_d_size,
    output logic              m0_d_source,
    output logic              m0_d_denied,
    output logic [DATA_W-1:0] m0_d_data,
    input  logic              m1_a_valid,
    output logic              m1_a_ready,
    input  logic [2:0]        m1_a_opcode,
    input  logic [2:0]        m1_a_param,
    input  logic [1:0]        m1_a_size,
    input  logic              m1_a_source,
    input  logic [ADDR_W-1:0] m1_a_address,
    input  logic [MASK_W-1:0] m1_a_mask,
    input  logic [DATA_W-1:0] m1_a_data,
    output logic              m1_d_valid,
    input  logic              m1_d_ready,
    output logic [2:0]        m1_d_opcode,
    output logic [1:0]        m1_d_size,
    output logic              m1_d_source,
    output logic              m1_d_denied,
    output logic [DATA_W-1:0] m1_d_data,
    output logic              s_a_valid,
    input  logic              s_a_ready,
    output logic [2:0]        s_a_opcode,
    output logic [2:0]        s_a_param,
    output logic [1:0]        s_a_size,
    output logic [1:0]        s_a_source,
    output logic [ADDR_W-1:0] s_a_address,
    output logic [MASK_W-1:0] s_a_mask,
    output logic [DATA_W-1:0] s_a_data,
    input  logic              s_d_valid,
    output logic              s_d_ready,
    input  logic [2:0]        s_d_opcode,
    input  logic [1:0]        s_d_size,
    input  logic [1:0]        s_d_source,
    input  logic              s_d_denied,
    input  logic [DATA_W-1:0] s_d_data,
    output logic              idle,
    output logic              d_unexpected
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    a_hdr_t            hdr [2];
    a_hdr_t            sel_hdr;
    logic [ADDR_W-1:0] addr [2];
    logic [CW-1:0]     cnt [2];
    logic [1:0]        elig, full, zero, unf, inc, dec;
    logic              grant, d_sel, a_fire, d_fire;
    logic              grant_q, grant_d, last_q, last_d, locked_q, locked_d;
    logic              d_unexpected_q, d_unexpected_d;

    assign hdr[0]  = '{m0_a_opcode, m0_a_param, m0_a_size, m0_a_source, m0_a_mask, m0_a_data};
    assign hdr[1]  = '{m1_a_opcode, m1_a_param, m1_a_size, m1_a_source, m1_a_mask, m1_a_data};
    assign addr[0] = m0_a_address;
    assign addr[1] = m1_a_address;
    assign elig    = {m1_a_valid && !full[1], m0_a_valid && !full[0]};

    always_comb begin
        // a presented-but-unaccepted request keeps its grant so its fields cannot change
        grant          = locked_q ? grant_q : (&elig) ? !last_q : elig[1];
        sel_hdr        = hdr[grant];
        s_a_valid      = !reset && elig[grant];
        s_a_opcode     = sel_hdr.opcode;
        s_a_param      = sel_hdr.param;
        s_a_size       = sel_hdr.size;
        s_a_source     = {grant, sel_hdr.source};
        s_a_address    = addr[grant];
        s_a_mask       = sel_hdr.mask;
        s_a_data       = sel_hdr.data;
        m0_a_ready     = !reset && !grant && s_a_ready && elig[0];
        m1_a_ready     = !reset && grant && s_a_ready && elig[1];
        d_sel          = s_d_source[1];
        m0_d_valid     = !reset && s_d_valid && !d_sel;
        m1_d_valid     = !reset && s_d_valid && d_sel;
        s_d_ready      = !reset && (d_sel ? m1_d_ready : m0_d_ready);
        m0_d_opcode    = s_d_opcode;
        m0_d_size      = s_d_size;
        m0_d_source    = s_d_source[0];
        m0_d_denied    = s_d_denied;
        m0_d_data      = s_d_data;
        m1_d_opcode    = s_d_opcode;
        m1_d_size      = s_d_size;
        m1_d_source    = s_d_source[0];
        m1_d_denied    = s_d_denied;
        m1_d_data      = s_d_data;
        a_fire         = s_a_valid && s_a_ready;
        d_fire         = s_d_valid && s_d_ready;
        inc            = {a_fire && grant, a_fire && !grant};
        dec            = {d_fire && d_sel, d_fire && !d_sel};
        grant_d        = grant;
        last_d         = a_fire ? grant : last_q;
        locked_d       = s_a_valid && !s_a_ready;
        d_unexpected_d = d_unexpected_q || |unf;
        idle           = &zero;
        d_unexpected   = d_unexpected_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q        <= 1'b0;
            last_q         <= 1'b1;
            locked_q       <= 1'b0;
            d_unexpected_q <= 1'b0;
        end else begin
            grant_q        <= grant_d;
            last_q         <= last_d;
            locked_q       <= locked_d;
            d_unexpected_q <= d_unexpected_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ctr
        tl_inflight_ctr #(.MAX(MAX_INFLIGHT), .W(CW)) u_ctr (
            .clock     (clock),
            .reset     (reset),
            .inc       (inc[g]),
            .dec       (dec[g]),
            .cnt       (cnt[g]),
            .full      (full[g]),
            .zero      (zero[g]),
            .underflow (unf[g])
        );
        a_cnt_le_max: assert property (@(posedge clock) disable iff (reset) cnt[g] <= CW'(MAX_INFLIGHT));
    end
endmodule

// File: doc/tl_ul_arbiter2.md
# tl_ul_arbiter2

Two-master TileLink-UL arbiter that shares one single-beat slave port (12-bit address, 32-bit data) between two requesters. It sits in front of the slave in the same position the TL protocol monitors observe. The block round-robins A-channel requests and tags each request's source with the master index. It routes D-channel responses back by that tag and caps the number of requests each master may have outstanding.

## Interface
- MAX_INFLIGHT, default 2: maximum outstanding A requests per master (1..7); counter width is clog2(MAX_INFLIGHT+1).
- ADDR_W, default 12: address width.
- Clock is `clock`, reset is `reset`. Reset is asynchronous, active-high; all state clears immediately on assertion.
- Ports named mN_* exist for N=0 and N=1.
- clock  in  1  block clock
- reset  in  1  asynchronous active-high reset
- mN_a_valid / mN_a_ready  in / out  1  master A handshake
- mN_a_opcode, mN_a_param  in  3  A opcode/param
- mN_a_size  in  2  log2 bytes (0..2)
- mN_a_source  in  1  master-local source ID
- mN_a_address  in  ADDR_W  byte address
- mN_a_mask  in  4  byte lanes
- mN_a_data  in  32  write data
- mN_d_valid / mN_d_ready  out / in  1  master D handshake
- mN_d_opcode  out  3  response opcode
- mN_d_size  out  2  response size
- mN_d_source  out  1  = s_d_source[0]
- mN_d_denied  out  1  response denied
- mN_d_data  out  32  read data
- s_a_valid / s_a_ready  out / in  1  slave A handshake
- s_a_opcode, s_a_param, s_a_size, s_a_address, s_a_mask, s_a_data  out  as above  muxed A fields
- s_a_source  out  2  {grant index, mN_a_source}
- s_d_valid / s_d_ready  in / out  1  slave D handshake
- s_d_opcode, s_d_size, s_d_source, s_d_denied, s_d_data  in  3/2/2/1/32  slave D fields
- idle  out  1  both in-flight counters zero
- d_unexpected  out  1  sticky: D response arrived for a master whose counter was 0

## Operation
- Eligible(N) = mN_a_valid && cnt[N] < MAX_INFLIGHT.
- Grant when unlocked: if only one master is eligible, it wins. If both are eligible, the master not granted last wins. Priority register `last` resets to 1, so m0 wins first.
- Lock: when s_a_valid && !s_a_ready, set `locked` and hold the current grant until the A fire. TL forbids changing a presented request.
- s_a_valid = Eligible(grant) (or locked). All s_a fields are muxed from the granted master.
- mN_a_ready = (grant==N) && s_a_ready && Eligible(N).
- On A fire, update `last` to grant and clear `locked`.
- D routing: s_d_source[1] selects master N. mN_d_valid = s_d_valid && sel==N, with fields passed through. s_d_ready = mN_d_ready of the selected master.
- Counters: cnt[N] increments on A fire from N and decrements on D fire to N. Both in one cycle leaves it unchanged.
- A D fire to N while cnt[N]==0: the counter stays 0 (no underflow) and d_unexpected sets; it clears only on reset.
- A masters size>2 are passed unchanged. Checking them is the monitor's job.

## Timing
- A and D paths are purely combinational (zero-cycle latency). Grant/lock/last/counters are registered on the rising edge of clock.
- The counter update is visible the cycle after the fire. A master at MAX_INFLIGHT whose D response fires in cycle t can fire A in t+1.
- Reset values: cnt=0, last=1, locked=0, d_unexpected=0, idle=1.
- While reset is high, s_a_valid, mN_a_ready, mN_d_valid and s_d_ready are forced 0.
- Reset mid-transaction discards in-flight accounting. The slave must be reset together with this block.
- Back-to-back fires are allowed: one A fire per cycle total, one D fire per cycle total.

## Structure
- Package tl_ul_pkg holds:
  - opcode constants (PutFullData=0, PutPartialData=1, Get=4, AccessAck=0, AccessAckData=1)
  - width constants (DATA_W=32, MASK_W=4)
  - an A-field struct type.
- Sub-module tl_inflight_ctr (inc, dec, MAX → cnt, full, zero, underflow) is instantiated twice.

## Test plan
- After reset, m0 and m1 both issue Get at cycle 1 with s_a_ready=1 → s_a_source=2'b00 at cycle 1, then 2'b10 at cycle 2; alternation continues.
- m1 is presented with s_a_ready=0 for 3 cycles while m0 raises valid in cycle 2 → grant stays m1 and fields stay stable until the fire in cycle 4.
- MAX_INFLIGHT=2: m0 issues 3 Gets with no D → the third is held (m0_a_ready=0). An AccessAckData with s_d_source=2'b01 at t makes m0_a_ready=1 at t+1, and the response routes to m0 with m0_d_source=1.
- A fire and a D fire for m1 in the same cycle with cnt=1 → cnt stays 1 and idle stays 0.
- s_d_valid with s_d_source=2'b10 while cnt[1]=0 → m1_d_valid=1, d_unexpected=1 next cycle and held until reset.
- Assert reset asynchronously mid-lock with cnt={1,2} → all handshake outputs 0 immediately, and idle=1 after reset.
